lsu_mmio: RTL and testbench
===========================

LSU_MMIO -- requirements
Module: lsu_mmio

Interface
REQ-001 SHALL have parameter DMEM_AW, default 11, meaning log2 of data-memory depth in 32-bit words (2048 words, 8 KiB).
REQ-002 SHALL have parameter N_HEX, default 8, range 1..8, meaning number of seven-segment digit registers.
REQ-003 SHALL have port clk_i, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port req_i, input, 1, access request, one access per cycle.
REQ-006 SHALL have port we_i, input, 1, 1 = store, 0 = load; qualified by req_i.
REQ-007 SHALL have port addr_i, input, 32, byte address.
REQ-008 SHALL have port size_i, input, 2, access size: 00 byte, 01 halfword, 10 word; 11 treated as word.
REQ-009 SHALL have port unsigned_i, input, 1, 1 = zero-extend loads, 0 = sign-extend loads.
REQ-010 SHALL have port st_data_i, input, 32, store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port ld_data_o, output, 32, extended load data, valid when ld_valid_o = 1.
REQ-012 SHALL have port ld_valid_o, output, 1, one-cycle pulse marking a completed load.
REQ-013 SHALL have port misalign_o, output, 1, one-cycle pulse marking a rejected misaligned access.
REQ-014 SHALL have port io_sw_i, input, 32, switch inputs.
REQ-015 SHALL have port io_key_i, input, 32, key inputs.
REQ-016 SHALL have ports io_ledr_o, io_ledg_o and io_lcd_o, each output, 32, register contents.
REQ-017 SHALL have port io_hex_o, output, 7*N_HEX, digit i in bits [7i+6:7i].

Function
REQ-018 SHALL use this address map:
- DMEM at 0x0000_0000..4*2^DMEM_AW-1.
- LEDR at 0x1000_7000; LEDG at 0x1000_7010.
- HEX i at 0x1000_7020+4i, for i < N_HEX.
- LCD at 0x1000_7040.
- SW at 0x1000_7800; KEY at 0x1000_7810.
REQ-019 SHALL treat an access as misaligned when size = half and addr[0] = 1, or size = word and addr[1:0] != 0.
REQ-020 SHALL respond to a misaligned access with:
- misalign_o = 1 in the next cycle;
- no state change;
- ld_valid_o = 0.
REQ-021 SHALL, on an aligned store, write only the addressed byte lanes (byte: lane addr[1:0]; half: lanes addr[1]*2..+1; word: all lanes) of the target DMEM word or output register.
REQ-022 SHALL map HEX stores to bits [6:0] of the write data and ignore all other bits.
REQ-023 SHALL make stores to SW, KEY or unmapped addresses no-ops with no error.
REQ-024 SHALL complete aligned loads with a fixed latency of 1 cycle, from req_i with we_i = 0 to ld_valid_o = 1 with ld_data_o.
REQ-025 SHALL extract the addressed lanes of a load and sign- or zero-extend them per unsigned_i.
REQ-026 SHALL return 0 for loads from unmapped addresses.
REQ-027 SHALL return the register value for loads from output registers; a HEX read returns {25'b0, digit}.
REQ-028 SHALL make a store in cycle N visible to a load issued in cycle N+1.
REQ-029 SHALL update io_* outputs in the cycle after the store, registered with no combinational path from inputs.
REQ-030 SHALL hold ld_data_o at its last value while ld_valid_o = 0.
REQ-031 SHALL ignore we_i, addr_i, size_i and st_data_i when req_i = 0.

Reset
REQ-032 SHALL, while rst_ni = 0, force to 0: ld_data_o, ld_valid_o, misalign_o, io_ledr_o, io_ledg_o, io_lcd_o, io_hex_o and the synchronizer flops.
REQ-033 SHALL leave DMEM contents unaffected by reset.
REQ-034 SHALL discard a load in flight when reset asserts; no ld_valid_o pulse follows deassertion.

Configuration
REQ-035 SHALL support macro LSU_MMIO_SYNC_EN to compile the input synchronizer in or out.
- Defined: io_sw_i and io_key_i pass through 2-flop synchronizers before read; a load sees an input change no earlier than 2 cycles after it.
- Undefined: inputs are sampled directly into the load data register; a change is visible to a load issued in the same cycle.

Verification
REQ-036 SHALL cover: store word 0xDEADBEEF to 0x0000_0010, then load word -> next cycle ld_valid_o = 1, ld_data_o = 0xDEADBEEF.
REQ-037 SHALL cover: store byte 0x80 to 0x0000_0013 over 0x11223344, then load byte signed -> 0xFFFF_FF80; load word -> 0x80223344.
REQ-038 SHALL cover: load half from 0x0000_0001 -> misalign_o = 1, ld_valid_o = 0; a store half of 0x1234 to 0x0000_0001 -> memory unchanged.
REQ-039 SHALL cover: store word 0x0000_00FF to HEX3 (0x1000_702C) -> io_hex_o[27:21] = 7'h7F next cycle; load from it -> 0x0000_007F.
REQ-040 SHALL cover: io_sw_i = 0x0000_0155, load SW -> 0x155 after 2 cycles with LSU_MMIO_SYNC_EN defined, or in the same cycle without it.
REQ-041 SHALL cover: assert rst_ni = 0 the cycle after a load request -> no ld_valid_o pulse, all io_* = 0, a DMEM word written earlier still reads back.

Source files
------------

// File: rtl/lsu_mmio_if.sv
// Core-side load/store request bus for lsu_mmio: one access per cycle,
// no backpressure, loads return a single-cycle valid pulse.
interface lsu_mmio_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] st_data_i;
  logic [31:0] ld_data_o;
  logic        ld_valid_o;
  logic        misalign_o;

  modport master (
    output req_i, we_i, addr_i, size_i, unsigned_i, st_data_i,
    input  ld_data_o, ld_valid_o, misalign_o
  );

  modport slave (
    input  req_i, we_i, addr_i, size_i, unsigned_i, st_data_i,
    output ld_data_o, ld_valid_o, misalign_o
  );
endinterface

// File: rtl/lsu_mmio.sv
// Load/store unit with DMEM and memory-mapped board I/O; loads return after 1 cycle, never stalls.
// Define LSU_MMIO_SYNC_EN to put 2-flop synchronizers on io_sw_i/io_key_i.
module lsu_mmio #(
  parameter int DMEM_AW = 11,
  parameter int N_HEX   = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  lsu_mmio_if.slave          bus,
  input  logic [31:0]        io_sw_i,
  input  logic [31:0]        io_key_i,
  output logic [31:0]        io_ledr_o,
  output logic [31:0]        io_ledg_o,
  output logic [31:0]        io_lcd_o,
  output logic [7*N_HEX-1:0] io_hex_o
);

  localparam logic [31:0] LEDR_ADDR = 32'h1000_7000;
  localparam logic [31:0] LEDG_ADDR = 32'h1000_7010;
  localparam logic [31:0] HEX_BASE  = 32'h1000_7020;
  localparam logic [31:0] LCD_ADDR  = 32'h1000_7040;
  localparam logic [31:0] SW_ADDR   = 32'h1000_7800;
  localparam logic [31:0] KEY_ADDR  = 32'h1000_7810;

  logic [31:0]        mem [2**DMEM_AW];
  logic [31:0]        ledr_q, ledg_q, lcd_q;
  logic [6:0]         hex_q [N_HEX];
  logic [31:0]        sw_rd, key_rd;

  logic               misalign, ld_req, st_req;
  logic               is_dmem, is_hex;
  logic               wr_ledr, wr_ledg, wr_lcd;
  logic [2:0]         hex_idx;
  logic [DMEM_AW-1:0] mem_idx;
  logic [29:0]        word_addr;
  logic [3:0]         be;
  logic [31:0]        wdata, rd_word, rd_shift, ld_ext;

  assign word_addr = bus.addr_i[31:2];
  assign mem_idx   = bus.addr_i[DMEM_AW+1:2];
  assign hex_idx   = bus.addr_i[4:2];
  assign is_dmem   = (bus.addr_i[31:DMEM_AW+2] == '0);
  assign is_hex    = (bus.addr_i[31:5] == HEX_BASE[31:5]) && (int'(hex_idx) < N_HEX);

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    misalign = 1'b0;
    be       = 4'b1111;
    wdata    = bus.st_data_i;
    case (bus.size_i)
      2'b00: begin
        be    = 4'b0001 << bus.addr_i[1:0];
        wdata = {4{bus.st_data_i[7:0]}};
      end
      2'b01: begin
        misalign = bus.addr_i[0];
        be       = bus.addr_i[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{bus.st_data_i[15:0]}};
      end
      default: misalign = (bus.addr_i[1:0] != 2'b00);
    endcase
  end

  assign ld_req  = bus.req_i & ~bus.we_i & ~misalign;
  assign st_req  = bus.req_i &  bus.we_i & ~misalign;
  assign wr_ledr = st_req && (word_addr == LEDR_ADDR[31:2]);
  assign wr_ledg = st_req && (word_addr == LEDG_ADDR[31:2]);
  assign wr_lcd  = st_req && (word_addr == LCD_ADDR[31:2]);

  always_comb begin
    rd_word = '0;
    if (is_dmem) begin
      rd_word = mem[mem_idx];
    end else if (is_hex) begin
      rd_word = {25'b0, hex_q[hex_idx]};
    end else begin
      case (word_addr)
        LEDR_ADDR[31:2]: rd_word = ledr_q;
        LEDG_ADDR[31:2]: rd_word = ledg_q;
        LCD_ADDR[31:2]:  rd_word = lcd_q;
        SW_ADDR[31:2]:   rd_word = sw_rd;
        KEY_ADDR[31:2]:  rd_word = key_rd;
        default:         rd_word = '0;
      endcase
    end
  end

  assign rd_shift = rd_word >> {bus.addr_i[1:0], 3'b000};

  always_comb begin
    case (bus.size_i)
      2'b00:   ld_ext = {{24{~bus.unsigned_i & rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   ld_ext = {{16{~bus.unsigned_i & rd_shift[15]}}, rd_shift[15:0]};
      default: ld_ext = rd_shift;
    endcase
  end

  // DMEM has no reset so its contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (st_req && is_dmem) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[mem_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.ld_data_o  <= '0;
      bus.ld_valid_o <= 1'b0;
      bus.misalign_o <= 1'b0;
      ledr_q         <= '0;
      ledg_q         <= '0;
      lcd_q          <= '0;
      for (int i = 0; i < N_HEX; i++) hex_q[i] <= '0;
    end else begin
      bus.ld_valid_o <= ld_req;
      bus.misalign_o <= bus.req_i & misalign;
      if (ld_req) bus.ld_data_o <= ld_ext;
      for (int b = 0; b < 4; b++) begin
        if (wr_ledr && be[b]) ledr_q[8*b +: 8] <= wdata[8*b +: 8];
        if (wr_ledg && be[b]) ledg_q[8*b +: 8] <= wdata[8*b +: 8];
        if (wr_lcd  && be[b]) lcd_q[8*b +: 8]  <= wdata[8*b +: 8];
      end
      // A digit lives in lane 0; stores that miss lane 0 leave it untouched.
      if (st_req && is_hex && be[0]) hex_q[hex_idx] <= wdata[6:0];
    end
  end

`ifdef LSU_MMIO_SYNC_EN
  logic [31:0] sw_s1, sw_s2, key_s1, key_s2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= '0;
      key_s2 <= '0;
    end else begin
      sw_s1  <= io_sw_i;
      sw_s2  <= sw_s1;
      key_s1 <= io_key_i;
      key_s2 <= key_s1;
    end
  end

  assign sw_rd  = sw_s2;
  assign key_rd = key_s2;
`else
  assign sw_rd  = io_sw_i;
  assign key_rd = io_key_i;
`endif

  assign io_ledr_o = ledr_q;
  assign io_ledg_o = ledg_q;
  assign io_lcd_o  = lcd_q;

  for (genvar g = 0; g < N_HEX; g++) begin : g_hex
    assign io_hex_o[7*g +: 7] = hex_q[g];
  end

endmodule

// File: tb/tb_lsu_mmio.sv
// Bench for lsu_mmio: byte-level reference model checked every cycle plus directed literal checks.
module tb_lsu_mmio;
  localparam int DMEM_AW    = 11;
  localparam int N_HEX      = 8;
  localparam int DMEM_BYTES = 4 * (1 << DMEM_AW);
  localparam logic [31:0] LEDR = 32'h1000_7000;
  localparam logic [31:0] LEDG = 32'h1000_7010;
  localparam logic [31:0] HEXB = 32'h1000_7020;
  localparam logic [31:0] LCD  = 32'h1000_7040;
  localparam logic [31:0] SW   = 32'h1000_7800;
  localparam logic [31:0] KEY  = 32'h1000_7810;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  logic [31:0] io_sw = '0;
  logic [31:0] io_key = '0;
  logic [31:0] ledr, ledg, lcd;
  logic [7*N_HEX-1:0] hex_o;

  always #5 clk = ~clk;

  lsu_mmio_if bus ();

  lsu_mmio #(.DMEM_AW(DMEM_AW), .N_HEX(N_HEX)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .bus       (bus),
    .io_sw_i   (io_sw),
    .io_key_i  (io_key),
    .io_ledr_o (ledr),
    .io_ledg_o (ledg),
    .io_lcd_o  (lcd),
    .io_hex_o  (hex_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit go = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, need 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  dm [int];
  logic [31:0] ledr_m = '0, ledg_m = '0, lcd_m = '0;
  logic [6:0]  hex_m [N_HEX];
  logic [31:0] sw_d1 = '0, sw_d2 = '0, key_d1 = '0, key_d2 = '0;
  logic        exp_vld = 1'b0, exp_mis = 1'b0;
  logic [31:0] exp_data = '0;

  function automatic logic [7:0] dm_rd(input int a);
    return dm.exists(a) ? dm[a] : 8'h00;
  endfunction

  function automatic logic [31:0] sw_view();
`ifdef LSU_MMIO_SYNC_EN
    return sw_d2;
`else
    return io_sw;
`endif
  endfunction

  function automatic logic [31:0] key_view();
`ifdef LSU_MMIO_SYNC_EN
    return key_d2;
`else
    return io_key;
`endif
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w < DMEM_BYTES) return {dm_rd(int'(w)+3), dm_rd(int'(w)+2), dm_rd(int'(w)+1), dm_rd(int'(w))};
    if (w == LEDR) return ledr_m;
    if (w == LEDG) return ledg_m;
    if (w == LCD)  return lcd_m;
    if (w >= HEXB && w < HEXB + 4*N_HEX) return {25'b0, hex_m[(w - HEXB) / 4]};
    if (w == SW)   return sw_view();
    if (w == KEY)  return key_view();
    return '0;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input int nb, input logic uns);
    logic [31:0] v;
    v = m_word(a) >> (8 * (a % 4));
    if (nb == 1) begin
      v = v & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (nb == 2) begin
      v = v & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic m_put(input logic [31:0] b, input logic [7:0] d);
    logic [31:0] w;
    int lane;
    w    = b & 32'hFFFF_FFFC;
    lane = int'(b % 4);
    if (b < DMEM_BYTES)                              dm[int'(b)] = d;
    else if (w == LEDR)                              ledr_m[8*lane +: 8] = d;
    else if (w == LEDG)                              ledg_m[8*lane +: 8] = d;
    else if (w == LCD)                               lcd_m[8*lane +: 8] = d;
    else if (w >= HEXB && w < HEXB + 4*N_HEX && lane == 0) hex_m[(w - HEXB) / 4] = d[6:0];
  endtask

  function automatic logic [7*N_HEX-1:0] hex_pack();
    logic [7*N_HEX-1:0] v;
    for (int i = 0; i < N_HEX; i++) v[7*i +: 7] = hex_m[i];
    return v;
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_vld = 1'b0; exp_mis = 1'b0; exp_data = '0;
      ledr_m = '0; ledg_m = '0; lcd_m = '0;
      for (int i = 0; i < N_HEX; i++) hex_m[i] = '0;
      sw_d1 = '0; sw_d2 = '0; key_d1 = '0; key_d2 = '0;
    end else begin
      int nb;
      exp_vld = 1'b0;
      exp_mis = 1'b0;
      if (bus.req_i) begin
        nb = nbytes(bus.size_i);
        if (bus.addr_i % nb != 0) exp_mis = 1'b1;
        else if (bus.we_i) begin
          for (int j = 0; j < nb; j++) m_put(bus.addr_i + j, bus.st_data_i[8*j +: 8]);
        end else begin
          exp_data = m_load(bus.addr_i, nb, bus.unsigned_i);
          exp_vld  = 1'b1;
        end
      end
      sw_d2 = sw_d1;  sw_d1 = io_sw;
      key_d2 = key_d1; key_d1 = io_key;
    end
  end

  always @(negedge clk) begin
    if (go) begin
      chk("ld_valid", {63'b0, bus.ld_valid_o}, {63'b0, exp_vld});
      chk("misalign", {63'b0, bus.misalign_o}, {63'b0, exp_mis});
      chk("ld_data",  {32'b0, bus.ld_data_o},  {32'b0, exp_data});
      chk("io_ledr",  {32'b0, ledr}, {32'b0, ledr_m});
      chk("io_ledg",  {32'b0, ledg}, {32'b0, ledg_m});
      chk("io_lcd",   {32'b0, lcd},  {32'b0, lcd_m});
      chk("io_hex",   64'(hex_o), 64'(hex_pack()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic acc(input logic w, input logic [31:0] a, input logic [1:0] sz,
                     input logic uns, input logic [31:0] d);
    bus.req_i = 1'b1; bus.we_i = w; bus.addr_i = a;
    bus.size_i = sz; bus.unsigned_i = uns; bus.st_data_i = d;
    @(posedge clk); #1;
    // Idle cycles carry store-looking junk aimed at DMEM; it must be ignored.
    bus.req_i = 1'b0; bus.we_i = 1'b1; bus.addr_i = 32'h10;
    bus.size_i = 2'b10; bus.st_data_i = $urandom;
  endtask

  task automatic st(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    acc(1'b1, a, sz, 1'b0, d);
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    acc(1'b0, a, sz, uns, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic lit_ld(input string nm, input logic [31:0] exp);
    chk({nm, ".vld"}, {63'b0, bus.ld_valid_o}, 64'd1);
    chk(nm, {32'b0, bus.ld_data_o}, {32'b0, exp});
  endtask

  initial begin
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0;
    bus.size_i = 2'b10; bus.unsigned_i = 1'b0; bus.st_data_i = '0;
    #1 rst_ni = 1'b0;
    #1 go = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("rst.ld_valid", {63'b0, bus.ld_valid_o}, 64'd0);
    chk("rst.ld_data",  {32'b0, bus.ld_data_o},  64'd0);
    chk("rst.ledr",     {32'b0, ledr}, 64'd0);
    chk("rst.hex",      64'(hex_o), 64'd0);
    rst_ni = 1'b1;
    io_key = 32'h0000_8001;
    idle(1);

    st(32'h10, 2'b10, 32'hDEAD_BEEF);
    ld(32'h10, 2'b10, 1'b0);            lit_ld("ld_word", 32'hDEAD_BEEF);
    idle(1);
    chk("hold.vld",  {63'b0, bus.ld_valid_o}, 64'd0);
    chk("hold.data", {32'b0, bus.ld_data_o},  64'hDEAD_BEEF);

    st(32'h10, 2'b10, 32'h1122_3344);
    st(32'h13, 2'b00, 32'h0000_0080);
    ld(32'h13, 2'b00, 1'b0);            lit_ld("ldb_s", 32'hFFFF_FF80);
    ld(32'h10, 2'b10, 1'b0);            lit_ld("ldw_merge", 32'h8022_3344);
    ld(32'h13, 2'b00, 1'b1);            lit_ld("ldb_u", 32'h0000_0080);
    ld(32'h12, 2'b01, 1'b0);            lit_ld("ldh_s", 32'hFFFF_8022);
    ld(32'h10, 2'b01, 1'b1);            lit_ld("ldh_u", 32'h0000_3344);

    st(32'h0, 2'b10, 32'hA5A5_A5A5);
    ld(32'h1, 2'b01, 1'b0);
    chk("mis_ld.mis",  {63'b0, bus.misalign_o}, 64'd1);
    chk("mis_ld.vld",  {63'b0, bus.ld_valid_o}, 64'd0);
    chk("mis_ld.data", {32'b0, bus.ld_data_o},  64'h0000_3344);
    st(32'h1, 2'b01, 32'h0000_1234);
    chk("mis_st.mis",  {63'b0, bus.misalign_o}, 64'd1);
    ld(32'h0, 2'b10, 1'b0);             lit_ld("mis_st.mem", 32'hA5A5_A5A5);
    ld(32'h2, 2'b10, 1'b0);
    chk("mis_w.mis",   {63'b0, bus.misalign_o}, 64'd1);
    st(32'h2, 2'b01, 32'h5555_BEEF);
    ld(32'h0, 2'b10, 1'b0);             lit_ld("sth_hi", 32'hBEEF_A5A5);

    st(32'h1000_702C, 2'b10, 32'h0000_00FF);
    chk("hex3", 64'(hex_o[27:21]), 64'h7F);
    ld(32'h1000_702C, 2'b10, 1'b0);     lit_ld("ld_hex3", 32'h0000_007F);
    st(32'h1000_702D, 2'b00, 32'h0000_0055);
    ld(32'h1000_702C, 2'b00, 1'b0);     lit_ld("hex_lane1", 32'h0000_007F);
    st(32'h1000_7020, 2'b10, 32'h0001_2345);

    st(LEDR, 2'b10, 32'hCAFE_F00D);
    st(LEDR + 2, 2'b01, 32'h0000_1234);
    chk("ledr_half", {32'b0, ledr}, 64'h1234_F00D);
    st(LEDG + 3, 2'b00, 32'h0000_00A5);
    chk("ledg_byte", {32'b0, ledg}, 64'hA500_0000);
    st(LCD, 2'b10, 32'h600D_F00D);
    ld(LCD + 2, 2'b01, 1'b0);           lit_ld("lcd_h", 32'h0000_600D);
    ld(LCD, 2'b00, 1'b0);               lit_ld("lcd_b", 32'h0000_000D);
    ld(LEDG + 3, 2'b00, 1'b0);          lit_ld("ledg_b", 32'hFFFF_FFA5);

    st(32'h2000_0000, 2'b10, 32'h1234_5678);
    ld(32'h2000_0000, 2'b10, 1'b0);     lit_ld("unmapped", 32'h0);
    st(SW, 2'b10, 32'hFFFF_FFFF);
    chk("st_sw.mis", {63'b0, bus.misalign_o}, 64'd0);
    st(32'h0000_2000, 2'b10, 32'h7777_7777);
    ld(32'h0000_2000, 2'b10, 1'b0);     lit_ld("past_dmem", 32'h0);
    ld(32'h1000_7004, 2'b10, 1'b0);     lit_ld("gap", 32'h0);

    ld(KEY, 2'b01, 1'b0);               lit_ld("key_h", 32'hFFFF_8001);
    ld(KEY + 1, 2'b00, 1'b1);           lit_ld("key_b", 32'h0000_0080);

    io_sw = 32'h0000_0155;
`ifdef LSU_MMIO_SYNC_EN
    ld(SW, 2'b10, 1'b0);                lit_ld("sw_early", 32'h0);
    idle(1);
`endif
    ld(SW, 2'b10, 1'b0);                lit_ld("sw", 32'h0000_0155);

    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h10;
    bus.size_i = 2'b10; bus.unsigned_i = 1'b0;
    #3 rst_ni = 1'b0;
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    chk("rstf.vld",  {63'b0, bus.ld_valid_o}, 64'd0);
    chk("rstf.ledr", {32'b0, ledr}, 64'd0);
    chk("rstf.lcd",  {32'b0, lcd},  64'd0);
    chk("rstf.hex",  64'(hex_o), 64'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("rstf.novld", {63'b0, bus.ld_valid_o}, 64'd0);
    end
    ld(32'h10, 2'b10, 1'b0);            lit_ld("dmem_keep", 32'h8022_3344);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
